ps2_mouse_init_sequencer: RTL

//  Host-side configuration controller for the PS/2 mouse. Sits between a PS/2 byte TX/RX

---
 rtl/ps2_mouse_init_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse host-side init sequencer.
// Runs the configuration script, checks each device response, retries the
// whole script on failure and raises Stream_On once the mouse is streaming.
module ps2_mouse_init_sequencer #(
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [7:0] SAMPLE_RATE    = 8'd100,
  parameter logic [7:0] RESOLUTION     = 8'd2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Tx_Valid,
  output logic [7:0] Tx_Data,
  input  logic       Tx_Ready,
  input  logic       Tx_Done,
  input  logic       Tx_Err,
  input  logic       Rx_Valid,
  input  logic [7:0] Rx_Data,
  output logic       Stream_On,
  output logic       Busy,
  output logic       Init_Fail,
  output logic [1:0] Retry_Count,
  output logic [3:0] State_Code
);

  // Timer must hold values up to TIMEOUT_CYCLES-1.
  localparam int         TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] MAX_R      = 2'(MAX_RETRIES);
  localparam logic [2:0] SCRIPT_LEN = 3'd6;
  localparam logic [1:0] MAX_RESEND = 2'd2;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_SEND    = 4'h1,
    S_TXWAIT  = 4'h2,
    S_ACK     = 4'h3,
    S_BAT     = 4'h4,
    S_ID      = 4'h5,
    S_NEXT    = 4'h6,
    S_RESTART = 4'h7,
    S_RUN     = 4'h8,
    S_FAIL    = 4'hF
  } state_t;

  state_t        state, state_n;
  logic [2:0]    step, step_n;
  logic [1:0]    retries, retries_n;
  logic [1:0]    resend, resend_n;
  logic [TW-1:0] timer, timer_n;
  logic          timeout;
  logic          wait_state_n;

  // Script bytes in send order: reset, set sample rate, set resolution, enable.
  function automatic logic [7:0] script_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    script_byte = 8'hFF;
      3'd1:    script_byte = 8'hF3;
      3'd2:    script_byte = SAMPLE_RATE;
      3'd3:    script_byte = 8'hE8;
      3'd4:    script_byte = RESOLUTION;
      3'd5:    script_byte = 8'hF4;
      default: script_byte = 8'h00;
    endcase
  endfunction

  assign timeout = (timer == TIMER_LAST);

  // Next-state logic; a received byte always beats the timeout terminal count.
  always_comb begin
    state_n   = state;
    step_n    = step;
    retries_n = retries;
    resend_n  = resend;
    case (state)
      S_IDLE, S_FAIL: begin
        if (Start) begin
          state_n   = S_SEND;
          step_n    = 3'd0;
          retries_n = 2'd0;
          resend_n  = 2'd0;
        end
      end
      S_SEND: begin
        if (Tx_Ready) state_n = S_TXWAIT;
      end
      S_TXWAIT: begin
        if (Tx_Err)       state_n = S_RESTART;
        else if (Tx_Done) state_n = S_ACK;
        else if (timeout) state_n = S_RESTART;
      end
      S_ACK: begin
        if (Rx_Valid) begin
          if (Rx_Data == RSP_ACK) begin
            state_n = (step == 3'd0) ? S_BAT : S_NEXT;
          end else if (Rx_Data == RSP_RESEND) begin
            if (resend == MAX_RESEND) begin
              state_n = S_RESTART;
            end else begin
              state_n  = S_SEND;
              resend_n = resend + 2'd1;
            end
          end else begin
            state_n = S_RESTART;
          end
        end else if (timeout) begin
          state_n = S_RESTART;
        end
      end
      S_BAT: begin
        if (Rx_Valid)     state_n = (Rx_Data == RSP_BAT_OK) ? S_ID : S_RESTART;
        else if (timeout) state_n = S_RESTART;
      end
      S_ID: begin
        if (Rx_Valid)     state_n = (Rx_Data == RSP_ID) ? S_NEXT : S_RESTART;
        else if (timeout) state_n = S_RESTART;
      end
      S_NEXT: begin
        step_n   = step + 3'd1;
        resend_n = 2'd0;
        state_n  = (step + 3'd1 == SCRIPT_LEN) ? S_RUN : S_SEND;
      end
      S_RESTART: begin
        if (retries == MAX_R) begin
          state_n = S_FAIL;
        end else begin
          state_n   = S_SEND;
          retries_n = retries + 2'd1;
          step_n    = 3'd0;
          resend_n  = 2'd0;
        end
      end
      S_RUN: begin
        state_n = S_RUN;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    wait_state_n = (state_n == S_TXWAIT) || (state_n == S_ACK) ||
                   (state_n == S_BAT)    || (state_n == S_ID);
    if (wait_state_n && (state_n == state)) timer_n = timer + TW'(1);
    else                                    timer_n = '0;
  end

  // State registers plus outputs decoded from the next state so every output is a flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      step        <= 3'd0;
      retries     <= 2'd0;
      resend      <= 2'd0;
      timer       <= '0;
      Tx_Valid    <= 1'b0;
      Tx_Data     <= 8'h00;
      Stream_On   <= 1'b0;
      Busy        <= 1'b0;
      Init_Fail   <= 1'b0;
      Retry_Count <= 2'd0;
      State_Code  <= 4'h0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      retries     <= retries_n;
      resend      <= resend_n;
      timer       <= timer_n;
      Tx_Valid    <= (state_n == S_SEND);
      Tx_Data     <= (state_n == S_SEND) ? script_byte(step_n) : Tx_Data;
      Stream_On   <= (state_n == S_RUN);
      Busy        <= !((state_n == S_IDLE) || (state_n == S_RUN) || (state_n == S_FAIL));
      Init_Fail   <= (state_n == S_FAIL);
      Retry_Count <= retries_n;
      State_Code  <= state_n;
    end
  end

endmodule
